fifo_rr_arbiter: RTL

- Single-clock N:1 round-robin arbiter that lets several val/rdy producers share one stream: the write port of an asynchronous FIFO crossing into another clock domain.
- Selects one valid requester per cycle and passes its message through combinationally.
- Reports which requester won, so the consumer side can route the data.
- Can optionally hold a grant for a burst of consecutive transfers from the same requester.

---
 rtl/fifo_rr_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: N:1 round-robin arbiter sharing one val/rdy stream.
// The winning message passes through combinationally, and ostream_src reports
// which requester won.
// Build option: define ARB_BURST_EN to hold a grant for up to p_max_burst
// consecutive transfers while the owner stays valid.
module fifo_rr_arbiter #(
    parameter int p_num_reqs  = 4,
    parameter int p_bit_width = 8,
    parameter int p_max_burst = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [p_num_reqs*p_bit_width-1:0] istream_msg,
    input  logic [p_num_reqs-1:0]             istream_val,
    output logic [p_num_reqs-1:0]             istream_rdy,
    output logic [p_bit_width-1:0]            ostream_msg,
    output logic                              ostream_val,
    input  logic                              ostream_rdy,
    output logic [$clog2(p_num_reqs)-1:0]     ostream_src
);
    localparam int PW = $clog2(p_num_reqs);
    localparam logic [PW-1:0] LastIdx = PW'(p_num_reqs - 1);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] scan_g;
    logic [PW-1:0] grant;
    logic [PW-1:0] cand_idx [p_num_reqs];
    logic          any_val;
    logic          xfer;

    // Candidate k is requester (ptr + k) mod N; ptr is always below N, so a
    // single conditional subtract is enough for the wrap.
    for (genvar gi = 0; gi < p_num_reqs; gi++) begin : g_cand
        assign cand_idx[gi] = (int'(ptr_q) + gi >= p_num_reqs)
                              ? PW'(int'(ptr_q) + gi - p_num_reqs)
                              : PW'(int'(ptr_q) + gi);
    end

    // Priority scan starting at ptr: walk from the lowest priority candidate
    // to the highest, so the last valid hit wins.
    always_comb begin
        scan_g = ptr_q;
        for (int k = p_num_reqs - 1; k >= 0; k--) begin
            if (istream_val[cand_idx[k]]) begin
                scan_g = cand_idx[k];
            end
        end
    end

`ifdef ARB_BURST_EN
    localparam int CW = $clog2(p_max_burst) + 1;

    typedef enum logic {
        IDLE,
        LOCKED
    } mode_e;

    mode_e         mode_q;
    mode_e         mode_d;
    logic [PW-1:0] owner_q;
    logic [PW-1:0] owner_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] new_cnt;
    logic          lock_active;

    // The lock only matters while its owner is still presenting data.
    assign lock_active = (mode_q == LOCKED) && istream_val[owner_q];
    assign grant       = lock_active ? owner_q : scan_g;

    // Burst state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q  <= IDLE;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            mode_q  <= mode_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    // Burst next state: extend or start a burst on each transfer, release when
    // the limit is reached or when the owner drops val.
    always_comb begin
        mode_d  = mode_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        new_cnt = lock_active ? (cnt_q + CW'(1)) : CW'(1);
        if (xfer) begin
            if (new_cnt < CW'(p_max_burst)) begin
                mode_d  = LOCKED;
                owner_d = grant;
                cnt_d   = new_cnt;
            end else begin
                mode_d  = IDLE;
                cnt_d   = '0;
            end
        end else if (!lock_active) begin
            mode_d = IDLE;
            cnt_d  = '0;
        end
    end
`else
    logic unused_max_burst;

    // Without bursting every transfer re-arbitrates, so the burst limit is moot.
    assign unused_max_burst = (p_max_burst > 0);
    assign grant            = scan_g;
`endif

    assign any_val     = |istream_val;
    assign ostream_val = any_val && !reset;
    assign xfer        = ostream_val && ostream_rdy;
    assign ostream_src = grant;
    assign ostream_msg = istream_msg[grant*p_bit_width +: p_bit_width];

    // Only the granted requester sees downstream ready.
    for (genvar gi = 0; gi < p_num_reqs; gi++) begin : g_rdy
        assign istream_rdy[gi] = xfer && (grant == PW'(gi));
    end

    // Next pointer: the requester after the one that just transferred.
    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (grant == LastIdx) ? '0 : (grant + PW'(1));
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
